// File: rtl/cmp_arb_pkg.sv
// Shared types for the comparator arbiter: op codes, request struct and result selection.
package cmp_arb_pkg;

  localparam int CMP_XLEN  = 32;
  localparam int CMP_TAG_W = 4;

  typedef logic [2:0] cmp_op_t;

  localparam cmp_op_t CMP_EQ   = 3'b000;
  localparam cmp_op_t CMP_NE   = 3'b001;
  localparam cmp_op_t CMP_SLT  = 3'b010;
  localparam cmp_op_t CMP_SLTU = 3'b011;
  localparam cmp_op_t CMP_LT   = 3'b100;
  localparam cmp_op_t CMP_GE   = 3'b101;
  localparam cmp_op_t CMP_LTU  = 3'b110;
  localparam cmp_op_t CMP_GEU  = 3'b111;

  typedef struct packed {
    cmp_op_t                op;
    logic [CMP_XLEN-1:0]    a;
    logic [CMP_XLEN-1:0]    b;
    logic [CMP_TAG_W-1:0]   tag;
  } cmp_req_t;

  // Bit order matches the rsp_flags port: {zero, slt, sltu}.
  typedef struct packed {
    logic zero;
    logic slt;
    logic sltu;
  } cmp_flags_t;

  function automatic logic cmp_select(input cmp_op_t op, input cmp_flags_t flags);
    logic res;
    case (op)
      CMP_EQ:             res = flags.zero;
      CMP_NE:             res = !flags.zero;
      CMP_SLT, CMP_LT:    res = flags.slt;
      CMP_GE:             res = !flags.slt;
      CMP_SLTU, CMP_LTU:  res = flags.sltu;
      default:            res = !flags.sltu;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/comp.sv
// Shared 32-bit comparator datapath: one subtractor yields equal, signed-less and unsigned-less.
module comp #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            zero,
  output logic            slt,
  output logic            sltu
);

  logic [XLEN:0] diff;

  // The extra top bit of the widened subtraction is the unsigned borrow.
  assign diff = {1'b0, a} - {1'b0, b};
  assign zero = (diff[XLEN-1:0] == '0);
  assign sltu = diff[XLEN];
  // When the signs differ the subtraction may overflow; the sign of a decides alone.
  assign slt  = (a[XLEN-1] != b[XLEN-1]) ? a[XLEN-1] : diff[XLEN-1];

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one comparator between branch (0) and ALU (1) requesters.
// Optional statistics counters are built when CMP_ARB_STATS_EN is defined.
module cmp_arbiter
  import cmp_arb_pkg::*;
#(
  // The request struct is sized by the package widths; keep these equal to them.
  parameter int XLEN  = CMP_XLEN,
  parameter int TAG_W = CMP_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [XLEN-1:0]  req0_a,
  input  logic [XLEN-1:0]  req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [XLEN-1:0]  req1_a,
  input  logic [XLEN-1:0]  req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_result,
  output logic [2:0]       rsp_flags
`ifdef CMP_ARB_STATS_EN
  ,
  output logic [31:0]      stat_grant0,
  output logic [31:0]      stat_grant1,
  output logic [31:0]      stat_stall
`endif
);

  logic       last;
  logic       can_acc;
  logic       grant0;
  logic       grant1;
  logic       accept;
  cmp_req_t   req0;
  cmp_req_t   req1;
  cmp_req_t   sel;
  cmp_flags_t flags;

  assign req0 = '{op: req0_op, a: req0_a, b: req0_b, tag: req0_tag};
  assign req1 = '{op: req1_op, a: req1_a, b: req1_b, tag: req1_tag};

  // Nothing is accepted during a reset cycle, so reset gates the stage-free term.
  assign can_acc    = !rst && (!rsp_valid || rsp_ready);
  assign grant0     = req0_valid && (!req1_valid || last);
  assign grant1     = req1_valid && (!req0_valid || !last);
  assign req0_ready = can_acc && grant0;
  assign req1_ready = can_acc && grant1;
  assign accept     = req0_ready || req1_ready;

  assign sel = grant1 ? req1 : req0;

  comp #(.XLEN(XLEN)) u_comp (
    .a    (sel.a),
    .b    (sel.b),
    .zero (flags.zero),
    .slt  (flags.slt),
    .sltu (flags.sltu)
  );

  // NOTE: all state is written with non-blocking assignments so every register
  // samples the pre-edge values of its peers regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_tag    <= '0;
      rsp_result <= 1'b0;
      rsp_flags  <= '0;
      last       <= 1'b1;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= grant1;
      rsp_tag    <= sel.tag;
      rsp_result <= cmp_select(sel.op, flags);
      rsp_flags  <= flags;
      last       <= grant1;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

`ifdef CMP_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grant0 <= '0;
      stat_grant1 <= '0;
      stat_stall  <= '0;
    end else begin
      if (req0_ready) stat_grant0 <= stat_grant0 + 32'd1;
      if (req1_ready) stat_grant1 <= stat_grant1 + 32'd1;
      if (rsp_valid && !rsp_ready) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule
